// File: rtl/ctrl_pipe_pkg.sv
// Shared types, defaults and helpers for the ctrl_pipe control-word carrier.
package ctrl_pipe_pkg;

    localparam int DEF_W         = 32;
    localparam int DEF_STAGES    = 4;
    localparam int DEF_EX_IDX    = 1;
    localparam int DEF_MC_BIT    = 0;
    localparam int DEF_MC_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Counter must hold MC_CYCLES-2; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode/hazard-unit side bundle of the control-word pipeline.
interface ctrl_pipe_if
    import ctrl_pipe_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int STAGES = DEF_STAGES
);

    logic [W-1:0]              ctrl_d;
    logic                      valid_d;
    logic [STAGES-1:0]         stall;
    logic [STAGES-1:0]         flush;
    logic [(STAGES-1)*W-1:0]   ctrl_q;
    logic [STAGES-2:0]         valid_q;
    logic                      mc_start;
    logic                      stall_req;

    modport master (
        output ctrl_d, valid_d, stall, flush,
        input  ctrl_q, valid_q, mc_start, stall_req
    );

    modport slave (
        input  ctrl_d, valid_d, stall, flush,
        output ctrl_q, valid_q, mc_start, stall_req
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: control word plus valid bit with flush, hold and bubble insert.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic [W-1:0] i_ctrl,
    input  logic         i_valid,
    output logic [W-1:0] o_ctrl,
    output logic         o_valid
);

    logic [W-1:0] r_ctrl;
    logic         r_valid;

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_ctrl  <= r_ctrl;
            r_valid <= r_valid;
        end else if (i_bubble) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= i_ctrl;
            r_valid <= i_valid;
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_valid = r_valid;

endmodule

// File: rtl/ctrl_pipe.sv
// Parametrised control-word pipeline with a multi-cycle sequencer that pins
// flagged words in the execute stage and asks the hazard unit to stall the front end.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int STAGES    = DEF_STAGES,
    parameter int EX_IDX    = DEF_EX_IDX,
    parameter int MC_BIT    = DEF_MC_BIT,
    parameter int MC_CYCLES = DEF_MC_CYCLES
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    localparam int             CW       = cnt_width(MC_CYCLES);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MC_CYCLES - 2);

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_next_cnt;
    logic              w_mc_start;
    logic              w_stall_req;
    logic              w_mc_hold;
    logic              w_ex_mc;
    logic [STAGES-1:0] w_hold;
    logic [W-1:0]      w_stage_ctrl  [STAGES];
    logic              w_stage_valid [STAGES];
    logic              w_unused_flush0;

    assign w_stage_ctrl[0]  = bus.ctrl_d;
    assign w_stage_valid[0] = bus.valid_d;
    assign w_unused_flush0  = bus.flush[0];

    // The start cycle holds EX as well, so a flagged word stays exactly MC_CYCLES cycles.
    assign w_mc_hold = w_mc_start | w_stall_req;

    for (genvar k = 0; k < STAGES; k++) begin : g_hold
        assign w_hold[k] = (k <= EX_IDX) ? (bus.stall[k] | w_mc_hold) : bus.stall[k];
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        ctrl_stage_reg #(.W(W)) u_reg (
            .clk      (clk),
            .rst      (rst),
            .i_flush  (bus.flush[k]),
            .i_hold   (w_hold[k]),
            .i_bubble (w_hold[k-1]),
            .i_ctrl   (w_stage_ctrl[k-1]),
            .i_valid  (w_stage_valid[k-1]),
            .o_ctrl   (w_stage_ctrl[k]),
            .o_valid  (w_stage_valid[k])
        );
    end

    // NOTE: every always_comb assigns its outputs a default first so no path infers a latch.
    always_comb begin
        bus.ctrl_q  = '0;
        bus.valid_q = '0;
        for (int k = 1; k < STAGES; k++) begin
            bus.ctrl_q[k*W-1 -: W] = w_stage_ctrl[k];
            bus.valid_q[k-1]       = w_stage_valid[k];
        end
    end

    assign w_ex_mc = w_stage_valid[EX_IDX] & w_stage_ctrl[EX_IDX][MC_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // r_cnt holds the BUSY cycles still to run; DONE blocks a restart while EX is held.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_mc_start) begin
                    w_next_cnt   = CNT_LOAD;
                    w_next_state = (MC_CYCLES > 2) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (bus.flush[EX_IDX]) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.flush[EX_IDX] || !w_hold[EX_IDX]) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_mc_start  = 1'b0;
        w_stall_req = 1'b0;
        case (r_state)
            IDLE:    w_mc_start  = w_ex_mc & ~bus.flush[EX_IDX];
            BUSY:    w_stall_req = 1'b1;
            default: ;
        endcase
    end

    assign bus.mc_start  = w_mc_start;
    assign bus.stall_req = w_stall_req;

endmodule
